sat_accumulator_16_bit: RTL and testbench
=========================================

# sat_accumulator_16_bit

Downstream consumer of the 16-bit signed subtractor stage. Takes each difference together with its positive/negative overflow flags, clamps it to the signed 16-bit range, and accumulates a burst of BURST_LEN differences into a saturating 16-bit running sum. The sum and a count of saturation events are presented on a valid/ready output once the burst completes. Sits between the subtractor datapath and any result-collection logic.

## Interface

- BURST_LEN, 8, number of differences accumulated per burst; legal range 1..255
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new burst; sampled only in IDLE
- in_valid  input  1  diff/OvP/OvN carry a valid difference
- in_ready  output  1  block accepts a difference this cycle
- diff  input  16  signed difference from the subtractor
- OvP  input  1  positive overflow flag accompanying diff
- OvN  input  1  negative overflow flag accompanying diff
- out_valid  output  1  out_sum/out_sat_count hold a completed burst result
- out_ready  input  1  downstream accepts the result
- out_sum  output  16  signed saturated sum of the burst
- out_sat_count  output  8  number of saturation events in the burst, saturating at 255
- busy  output  1  high in RUN or DONE

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 -> RUN, accumulator cleared to 0, sample counter to 0, sat counter to 0.
- RUN: in_ready=1. Transfer = in_valid & in_ready. Each transfer:
  - sample = +32767 if OvP; else -32768 if OvN; else diff. OvP has priority if both are set.
  - Input clamp (OvP or OvN set) counts one sat event.
  - acc_next = sign-extended 17-bit acc + sample; clamp to [-32768, +32767]. An accumulator clamp counts one sat event. A single transfer can count 2 events.
  - Sat counter saturates at 255; it never wraps.
  - Sample counter increments; on the BURST_LEN-th transfer -> DONE.
- DONE: out_valid=1; out_sum and out_sat_count hold the final values and stay stable until accepted. out_valid & out_ready -> IDLE.
- start is ignored in RUN and DONE.
- in_valid without in_ready (IDLE/DONE) is ignored and does not alter state.
- Reset (any state, any time): state=IDLE; accumulator, both counters, out_sum and out_sat_count = 0; in_ready, out_valid and busy = 0.

## Timing

- in_ready, out_valid and busy decode directly from state registers, with no combinational path from inputs.
- start at edge k -> in_ready=1 from cycle k+1.
- Transfers may arrive back-to-back. Minimum burst is BURST_LEN cycles in RUN.
- The last transfer at edge k -> out_valid=1 in cycle k+1, with out_sum reflecting that transfer.
- out_ready may be high before out_valid; the handshake completes in the first DONE cycle. IDLE follows on the next edge.
- start is accepted no earlier than the cycle after the return to IDLE. Minimum turnaround: DONE -> IDLE -> RUN.
- Asynchronous reset takes effect immediately. Deassertion is assumed synchronous to clk at the system level.

## Structure

- Shared package sat_acc_pkg:
  - state enum {IDLE, RUN, DONE}
  - constants SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000, SATCNT_MAX=8'd255
- Sub-module sat_clamp_17_to_16: purely combinational; 17-bit signed in, 16-bit clamped out, plus a clamped flag. Used for the accumulator add.
- Input clamp and counters stay in the top module.

## Test plan

- Reset mid-RUN: after 3 transfers, assert rst. All outputs are 0 immediately, and the next start begins a clean burst.
- Plain burst: BURST_LEN=8; diffs 100, -50, 7, 0, 1, -1, 200, -7; no flags; in_valid held high. out_valid is high 1 cycle after the 8th transfer, out_sum=250, out_sat_count=0.
- Input clamps: diff 0 with OvP=1, then diff 0 with OvN=1, then 6× diff 5. Samples are +32767 then -32768, so out_sum=29, out_sat_count=2.
- Accumulator saturation: 8× diff 20000, no flags.
  - out_sum=32767, out_sat_count=7.
  - The 2nd through 8th adds clamp; the 1st does not.
- Backpressure and gaps: in_valid toggles 1-0-1 with start pulsed during RUN. The start pulse is ignored and only 8 transfers count.
- Held result: out_ready held low 5 cycles in DONE. out_valid and out_sum stay stable; in_ready=0. With out_ready=1 the block returns to IDLE next cycle; start then restarts with acc=0.

Source files
------------

// File: rtl/sat_acc_pkg.sv
// Shared definitions for the saturating burst accumulator.
//   state_t    : burst controller states
//   SAT_MAX    : largest signed 16-bit value
//   SAT_MIN    : smallest signed 16-bit value
//   SATCNT_MAX : ceiling of the saturation-event counter
package sat_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic signed [15:0] SAT_MAX    = 16'sh7FFF;
   localparam logic signed [15:0] SAT_MIN    = 16'sh8000;
   localparam logic        [7:0]  SATCNT_MAX = 8'd255;

endpackage

// File: rtl/sat_clamp_17_to_16.sv
// Combinational clamp of a 17-bit signed value to the signed 16-bit range.
//   din     : 17-bit signed value (sum of two sign-extended 16-bit operands)
//   dout    : din clamped to [SAT_MIN, SAT_MAX]
//   clamped : high when din lay outside the 16-bit range
module sat_clamp_17_to_16
   import sat_acc_pkg::*;
(
   input  logic signed [16:0] din,
   output logic signed [15:0] dout,
   output logic               clamped
);

   // The value fits in 16 bits exactly when the top two bits agree;
   // otherwise bit 16 gives the true sign of the overflow.
   always_comb begin
      clamped = din[16] ^ din[15];
      if (!clamped)
         dout = din[15:0];
      else if (din[16])
         dout = SAT_MIN;
      else
         dout = SAT_MAX;
   end

endmodule

// File: rtl/sat_accumulator_16_bit.sv
// Saturating burst accumulator behind the 16-bit signed subtractor.
// Clamps each difference by its overflow flags, adds it into a saturating
// 16-bit sum, and presents the sum plus a saturation-event count once
// BURST_LEN differences have been taken.
//   clk, rst                 : clock, async active-high reset
//   start                    : begin a burst (IDLE only)
//   in_valid/in_ready        : difference handshake (diff, OvP, OvN)
//   out_valid/out_ready      : result handshake (out_sum, out_sat_count)
//   busy                     : high in RUN or DONE
module sat_accumulator_16_bit
   import sat_acc_pkg::*;
#(
   parameter int BURST_LEN = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] diff,
   input  logic        OvP,
   input  logic        OvN,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sum,
   output logic [7:0]  out_sat_count,
   output logic        busy
);

   localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

   state_t             state;
   logic signed [15:0] acc;
   logic [7:0]         smp_cnt;
   logic [7:0]         sat_cnt;

   logic signed [15:0] sample;
   logic               in_clamp;
   logic signed [16:0] sum17;
   logic signed [15:0] acc_next;
   logic               acc_clamp;
   logic [8:0]         sat_sum;
   logic [7:0]         sat_next;
   logic               xfer;

   // OvP wins when both flags are set; either flag is one saturation event.
   always_comb begin
      in_clamp = OvP | OvN;
      if (OvP)
         sample = SAT_MAX;
      else if (OvN)
         sample = SAT_MIN;
      else
         sample = diff;
   end

   assign sum17 = {acc[15], acc} + {sample[15], sample};

   sat_clamp_17_to_16 u_clamp (
      .din     (sum17),
      .dout    (acc_next),
      .clamped (acc_clamp)
   );

   // One transfer can add two events (input clamp and accumulator clamp).
   assign sat_sum  = {1'b0, sat_cnt} + 9'(in_clamp) + 9'(acc_clamp);
   assign sat_next = (sat_sum > {1'b0, SATCNT_MAX}) ? SATCNT_MAX : sat_sum[7:0];

   assign xfer = in_valid && (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         smp_cnt <= '0;
         sat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  acc     <= '0;
                  smp_cnt <= '0;
                  sat_cnt <= '0;
               end
            end
            RUN: begin
               if (xfer) begin
                  acc     <= acc_next;
                  sat_cnt <= sat_next;
                  smp_cnt <= smp_cnt + 8'd1;
                  if (smp_cnt == LAST_IDX)
                     state <= DONE;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake outputs come straight from the state register; the result
   // registers only move in RUN, so they hold steady throughout DONE.
   assign in_ready      = (state == RUN);
   assign out_valid     = (state == DONE);
   assign busy          = (state != IDLE);
   assign out_sum       = acc;
   assign out_sat_count = sat_cnt;

endmodule

// File: tb/tb_sat_accumulator_16_bit.sv
module tb_sat_accumulator_16_bit;

   localparam int NV = 7;

   typedef struct {
      string      name;
      logic [7:0] p;      // bit k = OvP on transfer k
      logic [7:0] n;      // bit k = OvN on transfer k
      logic [15:0] sum;
      logic [7:0]  cnt;
      logic        early; // out_ready raised before out_valid
   } vec_t;

   logic        clk = 0;
   logic        rst = 1;
   logic        start = 0, in_valid = 0, OvP = 0, OvN = 0, out_ready = 0;
   logic [15:0] diff = '0;
   logic        in_ready, out_valid, busy;
   logic [15:0] out_sum;
   logic [7:0]  out_sat_count;

   // second instance with the longest legal burst, for the counter ceiling
   logic        b_start = 0, b_in_valid = 0, b_OvP = 0, b_OvN = 0, b_out_ready = 0;
   logic [15:0] b_diff = '0;
   logic        b_in_ready, b_out_valid, b_busy;
   logic [15:0] b_out_sum;
   logic [7:0]  b_out_sat_count;

   int checks = 0;
   int errors = 0;

   vec_t               tbl [NV];
   logic signed [15:0] vd  [NV][8];

   always #5 clk = ~clk;

   sat_accumulator_16_bit #(.BURST_LEN(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .diff(diff), .OvP(OvP), .OvN(OvN), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_sat_count(out_sat_count), .busy(busy)
   );

   sat_accumulator_16_bit #(.BURST_LEN(255)) dut2 (
      .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .diff(b_diff), .OvP(b_OvP), .OvN(b_OvN), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sum(b_out_sum), .out_sat_count(b_out_sat_count), .busy(b_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // start, BURST_LEN back-to-back transfers, check result, handshake out
   task automatic run_vec(input int i);
      start = 1;
      @(negedge clk);
      start = 0;
      chk({tbl[i].name, " in_ready_run"}, 32'(in_ready), 1);
      for (int k = 0; k < 8; k++) begin
         in_valid = 1;
         diff     = vd[i][k];
         OvP      = tbl[i].p[k];
         OvN      = tbl[i].n[k];
         if (k == 7 && tbl[i].early) out_ready = 1;
         @(negedge clk);
      end
      in_valid = 0; OvP = 0; OvN = 0;
      chk({tbl[i].name, " out_valid"}, 32'(out_valid), 1);
      chk({tbl[i].name, " out_sum"}, 32'(out_sum), 32'(tbl[i].sum));
      chk({tbl[i].name, " sat_count"}, 32'(out_sat_count), 32'(tbl[i].cnt));
      chk({tbl[i].name, " in_ready_done"}, 32'(in_ready), 0);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({tbl[i].name, " back_idle"}, {out_valid, busy}, 0);
   endtask

   initial begin
      tbl[0] = '{"plain",    8'h00, 8'h00, 16'd250,  8'd0,  1'b0};
      vd[0]  = '{100, -50, 7, 0, 1, -1, 200, -7};
      tbl[1] = '{"in_clamp", 8'h01, 8'h02, 16'd29,   8'd2,  1'b0};
      vd[1]  = '{0, 0, 5, 5, 5, 5, 5, 5};
      tbl[2] = '{"acc_pos",  8'h00, 8'h00, 16'h7FFF, 8'd7,  1'b1};
      vd[2]  = '{20000, 20000, 20000, 20000, 20000, 20000, 20000, 20000};
      tbl[3] = '{"acc_neg",  8'h00, 8'h00, 16'h8000, 8'd7,  1'b0};
      vd[3]  = '{-20000, -20000, -20000, -20000, -20000, -20000, -20000, -20000};
      // first transfer: input clamp only; later ones: input + accumulator
      tbl[4] = '{"all_ovp",  8'hFF, 8'h00, 16'h7FFF, 8'd15, 1'b0};
      vd[4]  = '{0, 0, 0, 0, 0, 0, 0, 0};
      tbl[5] = '{"all_ovn",  8'h00, 8'hFF, 16'h8000, 8'd15, 1'b1};
      vd[5]  = '{0, 0, 0, 0, 0, 0, 0, 0};
      // both flags: OvP wins, one event; 32767 - 7
      tbl[6] = '{"both_flg", 8'h01, 8'h01, 16'h7FF8, 8'd1,  1'b0};
      vd[6]  = '{0, -1, -1, -1, -1, -1, -1, -1};

      // reset state
      #2;
      chk("reset_state", {in_ready, out_valid, busy, out_sum, out_sat_count}, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("idle_state", {in_ready, out_valid, busy}, 0);

      // reset mid-RUN after 3 transfers
      start = 1;
      @(negedge clk);
      start = 0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; diff = 16'd10;
         @(negedge clk);
      end
      in_valid = 0;
      chk("mid_sum", 32'(out_sum), 30);
      rst = 1;
      #1;
      chk("async_rst", {in_ready, out_valid, busy, out_sum, out_sat_count}, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) run_vec(i);

      // gaps in in_valid with start pulsed during the gaps
      start = 1;
      @(negedge clk);
      start = 0;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1; diff = 16'(k + 1);
         @(negedge clk);
         if (k < 7) begin
            in_valid = 0; diff = 16'd999; start = 1;
            @(negedge clk);
            start = 0;
            chk("gap_no_done", 32'(out_valid), 0);
         end
      end
      in_valid = 0;
      chk("gap_valid", 32'(out_valid), 1);
      chk("gap_sum", 32'(out_sum), 36);
      chk("gap_cnt", 32'(out_sat_count), 0);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;

      // held result under backpressure; input and start ignored in DONE
      start = 1;
      @(negedge clk);
      start = 0;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1; diff = 16'd1000;
         @(negedge clk);
      end
      for (int c = 0; c < 5; c++) begin
         in_valid = 1; diff = 16'd5; start = 1; OvP = 1;
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_sum", 32'(out_sum), 8000);
         chk("hold_cnt", 32'(out_sat_count), 0);
         chk("hold_in_ready", 32'(in_ready), 0);
      end
      in_valid = 0; start = 0; OvP = 0; out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("hold_release", {out_valid, in_ready, busy}, 0);
      start = 1;
      @(negedge clk);
      start = 0;
      chk("restart_run", {in_ready, busy}, 2'b11);
      chk("restart_acc", 32'(out_sum), 0);
      for (int k = 0; k < 8; k++) begin
         in_valid = 1; diff = 16'hFFFF;
         @(negedge clk);
      end
      in_valid = 0;
      chk("restart_sum", 32'(out_sum), 32'(16'hFFF8));
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;

      // 255-transfer burst of OvP: 1 + 2*254 events, capped at 255
      b_start = 1;
      @(negedge clk);
      b_start = 0;
      for (int k = 0; k < 255; k++) begin
         b_in_valid = 1; b_OvP = 1;
         @(negedge clk);
         if (k == 253) chk("long_not_done", 32'(b_out_valid), 0);
      end
      b_in_valid = 0; b_OvP = 0;
      chk("long_valid", 32'(b_out_valid), 1);
      chk("long_sum", 32'(b_out_sum), 32'(16'h7FFF));
      chk("long_cnt_cap", 32'(b_out_sat_count), 255);
      b_out_ready = 1;
      @(negedge clk);
      b_out_ready = 0;
      chk("long_idle", {b_out_valid, b_busy}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
